load_store_unit: RTL

- Initiator side of the data-memory interface. Sits between the execute stage and the word-addressed data memory.
- Accepts byte, halfword and word load/store requests from the pipeline and drives the memory's write-enable, address and write-data. The memory reads combinationally and writes on the rising clock edge.
- Performs lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses; these never touch memory.

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_lanes.sv | 44 ++++
 rtl/load_store_unit.sv | 127 ++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the word-index slice of a byte address.
package load_store_unit_pkg;

   localparam int DATA_W  = 32;
   localparam int WORD_HI = 31;
   localparam int WORD_LO = 2;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_READ,
      WRITE,
      DONE
   } state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake plus data-memory bus of the load/store unit.
// The slave side is the unit; the master side is the pipeline together
// with the memory that returns read data.
interface load_store_unit_if;

   logic        Req_Valid;
   logic        Req_Ready;
   logic        Req_Write;
   logic [1:0]  Req_Size;
   logic        Req_Unsigned;
   logic [31:0] Req_Address;
   logic [31:0] Req_Write_Data;
   logic        Resp_Valid;
   logic        Resp_Error;
   logic [31:0] Resp_Load_Data;
   logic        Mem_Write;
   logic [31:0] Mem_Address;
   logic [31:0] Mem_Write_Data;
   logic [31:0] Mem_Read_Data;

   modport master (
      output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Address,
             Req_Write_Data, Mem_Read_Data,
      input  Req_Ready, Resp_Valid, Resp_Error, Resp_Load_Data,
             Mem_Write, Mem_Address, Mem_Write_Data
   );

   modport slave (
      input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Address,
             Req_Write_Data, Mem_Read_Data,
      output Req_Ready, Resp_Valid, Resp_Error, Resp_Load_Data,
             Mem_Write, Mem_Address, Mem_Write_Data
   );

endinterface

// File: rtl/load_store_lanes.sv
// Little-endian lane handling: extracts and extends a byte/halfword from a
// read word, and merges right-aligned store data into a read word.
module load_store_lanes
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rd_word,
   input  logic [1:0]  offset,
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [31:0] st_data,
   output logic [31:0] ld_data,
   output logic [31:0] st_word
);

   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   // Load path: select the addressed lane, then sign- or zero-extend it.
   always_comb begin
      lane_b  = rd_word[{offset, 3'b000} +: 8];
      lane_h  = offset[1] ? rd_word[31:16] : rd_word[15:0];
      ld_data = rd_word;
      case (size)
         SIZE_BYTE: ld_data = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
         SIZE_HALF: ld_data = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default:   ld_data = rd_word;
      endcase
   end

   // Store path: overwrite only the addressed lane of the current word.
   always_comb begin
      st_word = rd_word;
      case (size)
         SIZE_BYTE: st_word[{offset, 3'b000} +: 8] = st_data[7:0];
         SIZE_HALF: begin
            if (offset[1]) st_word[31:16] = st_data[15:0];
            else           st_word[15:0]  = st_data[15:0];
         end
         SIZE_WORD: st_word = st_data;
         default:   st_word = rd_word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, checks alignment and
// range, and performs loads, word stores or read-modify-write sub-word
// stores against a combinational-read data memory.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_WORDS = 1024
)
(
   input logic         Clk,
   input logic         Reset,
   load_store_unit_if.slave bus
);

   state_e      state, state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   size_e       size_q;
   logic        write_q;
   logic        uns_q;
   logic        err_q;
   logic        accept;
   logic        req_err;
   logic [31:0] ld_ext;
   logic [31:0] st_merged;

   assign accept = bus.Req_Valid && (state == IDLE);

   assign bus.Mem_Address    = {addr_q[WORD_HI:WORD_LO], 2'b00};
   assign bus.Mem_Write_Data = wdata_q;
   assign bus.Resp_Load_Data = rdata_q;

   load_store_lanes u_lanes (
      .rd_word     (bus.Mem_Read_Data),
      .offset      (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .st_data     (wdata_q),
      .ld_data     (ld_ext),
      .st_word     (st_merged)
   );

   // Classify the incoming request: illegal size, misalignment or out-of-range word.
   always_comb begin
      req_err = 1'b0;
      case (size_e'(bus.Req_Size))
         SIZE_BYTE: req_err = 1'b0;
         SIZE_HALF: req_err = bus.Req_Address[0];
         SIZE_WORD: req_err = |bus.Req_Address[1:0];
         default:   req_err = 1'b1;
      endcase
      if ({2'b00, bus.Req_Address[WORD_HI:WORD_LO]} >= 32'(MEM_WORDS))
         req_err = 1'b1;
   end

   // FSM state register.
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and control outputs; the write strobe is killed by reset.
   always_comb begin
      state_nxt      = state;
      bus.Req_Ready  = 1'b0;
      bus.Resp_Valid = 1'b0;
      bus.Resp_Error = 1'b0;
      bus.Mem_Write  = 1'b0;
      case (state)
         IDLE: begin
            bus.Req_Ready = 1'b1;
            if (accept) begin
               if (req_err)                                state_nxt = DONE;
               else if (!bus.Req_Write)                    state_nxt = LOAD;
               else if (size_e'(bus.Req_Size) == SIZE_WORD) state_nxt = WRITE;
               else                                        state_nxt = RMW_READ;
            end
         end
         LOAD:     state_nxt = DONE;
         RMW_READ: state_nxt = WRITE;
         WRITE: begin
            bus.Mem_Write = write_q && !Reset;
            state_nxt     = DONE;
         end
         DONE: begin
            bus.Resp_Valid = 1'b1;
            bus.Resp_Error = err_q;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, load result and store-merge registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         size_q  <= SIZE_BYTE;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q  <= bus.Req_Address;
                  size_q  <= size_e'(bus.Req_Size);
                  write_q <= bus.Req_Write;
                  uns_q   <= bus.Req_Unsigned;
                  wdata_q <= bus.Req_Write_Data;
                  err_q   <= req_err;
                  // An error response carries no data; clear it as DONE is entered.
                  if (req_err) rdata_q <= '0;
               end
            end
            LOAD:     rdata_q <= ld_ext;
            RMW_READ: wdata_q <= st_merged;
            WRITE:    rdata_q <= '0;
            default: ;
         endcase
      end
   end

endmodule
